fetch_stage: RTL and testbench

- Instruction fetch front end that sits directly upstream of the decode/execute datapath (ALU, register, three-stage pipeline).
- Owns the program counter and issues in-order word requests to an instruction memory with a valid/ready request channel and a fixed-order response channel.
- Buffers returned instructions with their PC in a small FIFO and presents them to the consumer over a valid/ready handshake.
- Supports a redirect (branch/jump target) that flushes buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 79 +++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing in-order instruction fetches, buffering responses
// with their PC in a small FIFO, with credit-based flow control and redirect flush.
module fetch_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [AWIDTH-1:0] r_pc, r_rsp_pc;
  logic [CW-1:0] r_out, r_drop, r_cnt;
  logic [PW-1:0] r_rd, r_wr;
  logic [DWIDTH-1:0] r_insn [FIFO_DEPTH];
  logic [AWIDTH-1:0] r_ipc [FIFO_DEPTH];
  logic [CW+1:0] w_used;
  logic [AWIDTH-1:0] w_tgt;
  logic w_acc, w_pop, w_rsp_drop, w_rsp_take, w_push;
  // Every slot is reserved at request time, so buffered + in-flight never exceeds the FIFO.
  assign w_used = (CW+2)'(r_cnt) + (CW+2)'(r_out) + (CW+2)'(r_drop);
  assign imem_req_valid_o = !rst && !redirect_i && w_used < (CW+2)'(FIFO_DEPTH);
  assign imem_req_addr_o = r_pc;
  assign w_acc = imem_req_valid_o && imem_req_ready_i;
  assign insn_valid_o = r_cnt != '0;
  assign w_pop = insn_valid_o && insn_ready_i;
  assign w_rsp_drop = imem_rsp_valid_i && r_drop != '0;
  assign w_rsp_take = imem_rsp_valid_i && r_drop == '0 && r_out != '0;
  assign w_push = w_rsp_take && !redirect_i;
  assign w_tgt = {redirect_pc_i[AWIDTH-1:2], 2'b00};
  assign insn_o = insn_valid_o ? r_insn[r_rd] : '0;
  assign pc_o = insn_valid_o ? r_ipc[r_rd] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= BASE_ADDR;
      r_rsp_pc <= BASE_ADDR;
      r_out <= '0;
      r_drop <= '0;
      r_cnt <= '0;
      r_rd <= '0;
      r_wr <= '0;
    end else if (redirect_i) begin
      r_pc <= w_tgt;
      r_rsp_pc <= w_tgt;
      r_drop <= r_drop + r_out - CW'(w_rsp_drop || w_rsp_take);
      r_out <= '0;
      r_cnt <= '0;
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      r_pc <= w_acc ? r_pc + AWIDTH'(4) : r_pc;
      r_rsp_pc <= w_push ? r_rsp_pc + AWIDTH'(4) : r_rsp_pc;
      r_drop <= r_drop - CW'(w_rsp_drop);
      r_out <= r_out + CW'(w_acc) - CW'(w_rsp_take);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_wr <= w_push ? r_wr + PW'(1) : r_wr;
      r_rd <= w_pop ? r_rd + PW'(1) : r_rd;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_insn[r_wr] <= imem_rsp_data_i;
      r_ipc[r_wr] <= r_rsp_pc;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench with a transaction-level reference model
// (in-flight request list tagged live/stale, plus an output queue).
module tb_fetch_stage;
  localparam int DEPTH = 2;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  typedef struct {logic [31:0] addr; bit live; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] insn;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid_o, imem_req_ready_i = 1'b0, imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_req_addr_o, imem_rsp_data_i = '0, redirect_pc_i = '0, insn_o, pc_o;
  logic redirect_i = 1'b0, insn_valid_o, insn_ready_i = 1'b0;
  int n_chk = 0, n_fail = 0, gcyc = 0, cyc = 0;
  int p_ir = 100, p_rr = 100, p_rsp = 100, p_redir = 0, lat_lo = 1, lat_hi = 1, redir_at = -1;
  logic [31:0] redir_pc = '0, m_pc = BASE;
  bit stale_rsp = 0;
  req_t pend[$];
  ent_t mq[$];
  logic [31:0] acc_log[$], pop_pc[$], pop_insn[$];

  fetch_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .insn_valid_o(insn_valid_o), .insn_ready_i(insn_ready_i), .insn_o(insn_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    redirect_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_req_ready_i = 1'b0;
    stale_rsp = 0;
    #1;
    chk("rst_insn_valid", 32'(insn_valid_o), 0);
    chk("rst_req_valid", 32'(imem_req_valid_o), 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_insn_o", insn_o, 0);
    m_pc = BASE;
    pend.delete();
    mq.delete();
    acc_log.delete();
    pop_pc.delete();
    pop_insn.delete();
    cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // One cycle: drive inputs, compare DUT against the model, then advance the model.
  task automatic step();
    req_t e;
    ent_t q;
    bit have, exp_rv, acc, pop, push;
    @(negedge clk);
    insn_ready_i = $urandom_range(99) < p_ir;
    imem_req_ready_i = $urandom_range(99) < p_rr;
    redirect_i = (cyc == redir_at) || ($urandom_range(99) < p_redir);
    redirect_pc_i = (cyc == redir_at) ? redir_pc :
                    ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom);
    have = pend.size() != 0 && pend[0].due <= gcyc && $urandom_range(99) < p_rsp;
    imem_rsp_valid_i = have || stale_rsp;
    imem_rsp_data_i = have ? (pend[0].addr ^ KEY) : $urandom;
    #1;
    exp_rv = !redirect_i && (pend.size() + mq.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid_o), 32'(exp_rv));
    chk("req_addr", imem_req_addr_o, m_pc);
    chk("insn_valid", 32'(insn_valid_o), 32'(mq.size() != 0));
    chk("pc_o", pc_o, mq.size() != 0 ? mq[0].pc : 32'h0);
    chk("insn_o", insn_o, mq.size() != 0 ? mq[0].insn : 32'h0);
    acc = exp_rv && imem_req_ready_i;
    pop = !redirect_i && mq.size() != 0 && insn_ready_i;
    push = 0;
    if (have) begin
      e = pend.pop_front();
      push = e.live && !redirect_i;
      q = '{pc: e.addr, insn: e.addr ^ KEY};
    end
    if (pop) begin
      pop_pc.push_back(mq[0].pc);
      pop_insn.push_back(mq[0].insn);
      void'(mq.pop_front());
    end
    if (push) mq.push_back(q);
    if (redirect_i) begin
      mq.delete();
      foreach (pend[i]) pend[i].live = 0;
      m_pc = {redirect_pc_i[31:2], 2'b00};
    end
    if (acc) begin
      acc_log.push_back(m_pc);
      pend.push_back('{addr: m_pc, live: 1, due: gcyc + $urandom_range(lat_hi, lat_lo)});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    gcyc++;
    cyc++;
  endtask

  initial begin
    do_reset();
    // streaming with a 1-cycle memory
    repeat (12) step();
    chk("first_req", acc_log[0], 32'h0100_0000);
    chk("out0_pc", pop_pc[0], 32'h0100_0000);
    chk("out0_insn", pop_insn[0], 32'hA4A5_0000);
    chk("out1_pc", pop_pc[1], 32'h0100_0004);
    chk("out1_insn", pop_insn[1], 32'hA4A5_0004);
    chk("out2_pc", pop_pc[2], 32'h0100_0008);
    // consumer back-pressure
    do_reset();
    p_ir = 0;
    repeat (10) step();
    #1;
    chk("bp_req_count", 32'(acc_log.size()), 2);
    chk("bp_valid", 32'(insn_valid_o), 1);
    chk("bp_pc", pc_o, 32'h0100_0000);
    p_ir = 100;
    repeat (6) step();
    chk("bp_rel0", pop_pc[0], 32'h0100_0000);
    chk("bp_rel1", pop_pc[1], 32'h0100_0004);
    chk("bp_rel2", pop_pc[2], 32'h0100_0008);
    // memory stall holds the address
    do_reset();
    p_rr = 0;
    repeat (3) begin
      step();
      #1 chk("stall_addr", imem_req_addr_o, 32'h0100_0000);
    end
    chk("stall_no_acc", 32'(acc_log.size()), 0);
    p_rr = 100;
    step();
    #1 chk("stall_acc_addr", acc_log[0], 32'h0100_0000);
    chk("stall_pc_adv", imem_req_addr_o, 32'h0100_0004);
    // redirect with two requests in flight on a 3-cycle memory
    do_reset();
    lat_lo = 3; lat_hi = 3; redir_at = 2; redir_pc = 32'h0200_0007;
    repeat (14) step();
    chk("redir_acc", acc_log[2], 32'h0200_0004);
    chk("redir_out", pop_pc[0], 32'h0200_0004);
    chk("redir_insn", pop_insn[0], 32'h0200_0004 ^ KEY);
    // redirect coinciding with a response and a pending pop
    do_reset();
    lat_lo = 2; lat_hi = 2; redir_at = 3; redir_pc = 32'h0300_0000;
    repeat (4) step();
    #1;
    chk("flush_valid", 32'(insn_valid_o), 0);
    chk("flush_no_pop", 32'(pop_pc.size()), 0);
    chk("flush_no_req", 32'(acc_log.size()), 2);
    repeat (10) step();
    chk("flush_after", pop_pc[0], 32'h0300_0000);
    // PC wrap through a misaligned redirect near the top of memory
    do_reset();
    lat_lo = 1; lat_hi = 1; redir_at = 0; redir_pc = 32'hFFFF_FFFE;
    repeat (10) step();
    chk("wrap0", pop_pc[0], 32'hFFFF_FFFC);
    chk("wrap1", pop_pc[1], 32'h0000_0000);
    // mid-stream async reset, then a stray response while nothing is outstanding
    redir_at = -1; p_ir = 60;
    repeat (6) step();
    do_reset();
    p_rr = 0; stale_rsp = 1;
    repeat (2) step();
    stale_rsp = 0; p_rr = 100;
    step();
    chk("post_rst_req", acc_log[0], 32'h0100_0000);
    chk("post_rst_empty", 32'(pop_pc.size()), 0);
    // randomized traffic
    p_ir = 60; p_rr = 70; p_rsp = 80; p_redir = 5; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
